// File: rtl/tage_branch_queue_if.sv
// Signal bundle between the fetch-side predictor, branch resolution and the TAGE update port.
// The queue owns the slave side; the environment that feeds it uses master.
interface tage_branch_queue_if #(
    parameter int DEPTH = 8,
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
) ();
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic             pred_valid;
    logic             pred_ready;
    logic [PC_W-1:0]  pred_pc;
    logic [1:0]       pred_ctr;
    logic             res_valid;
    logic             res_ready;
    logic             res_taken;
    logic             flush;
    logic             update_valid;
    logic [PC_W-1:0]  update_pc;
    logic             update_taken;
    logic [1:0]       update_pred;
    logic             mispredict;
    logic [OCC_W-1:0] occupancy;
    logic [CNT_W-1:0] stat_branches;
    logic [CNT_W-1:0] stat_mispred;

    modport slave (
        input  pred_valid, pred_pc, pred_ctr, res_valid, res_taken, flush,
        output pred_ready, res_ready, update_valid, update_pc, update_taken,
               update_pred, mispredict, occupancy, stat_branches, stat_mispred
    );

    modport master (
        output pred_valid, pred_pc, pred_ctr, res_valid, res_taken, flush,
        input  pred_ready, res_ready, update_valid, update_pc, update_taken,
               update_pred, mispredict, occupancy, stat_branches, stat_mispred
    );
endinterface

// File: rtl/tage_branch_queue.sv
// In-order queue pairing predicted branches with their resolved direction and
// producing a registered TAGE update pulse plus saturating branch statistics.
module tage_branch_queue #(
    parameter int DEPTH = 8,
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
) (
    input logic               clk,
    input logic               rst,
    tage_branch_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [PC_W+1:0]  r_mem [DEPTH];
    logic [AW-1:0]    r_head;
    logic [AW-1:0]    r_tail;
    logic [AW:0]      r_count;

    logic             r_upd_valid;
    logic [PC_W-1:0]  r_upd_pc;
    logic             r_upd_taken;
    logic [1:0]       r_upd_pred;
    logic             r_mispredict;
    logic [CNT_W-1:0] r_stat_br;
    logic [CNT_W-1:0] r_stat_mis;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_mis;
    logic [PC_W+1:0]  w_head_ent;

    assign w_full     = (r_count == CNT_FULL);
    assign w_empty    = (r_count == '0);
    // Flush suppresses both sides so neither the storage nor the update path moves.
    assign w_push     = bus.pred_valid & ~w_full  & ~bus.flush;
    assign w_pop      = bus.res_valid  & ~w_empty & ~bus.flush;
    assign w_head_ent = r_mem[r_head];
    assign w_mis      = w_head_ent[1] ^ bus.res_taken;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= {bus.pred_pc, bus.pred_ctr};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (bus.flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + AW'(1);
            if (w_pop)  r_head <= r_head + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Stats advance on the same edge that raises update_valid, so they already
    // include the branch being reported while the pulse is visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_upd_valid  <= 1'b0;
            r_upd_pc     <= '0;
            r_upd_taken  <= 1'b0;
            r_upd_pred   <= '0;
            r_mispredict <= 1'b0;
            r_stat_br    <= '0;
            r_stat_mis   <= '0;
        end else begin
            r_upd_valid  <= w_pop;
            r_mispredict <= w_pop & w_mis;
            if (w_pop) begin
                r_upd_pc    <= w_head_ent[PC_W+1:2];
                r_upd_pred  <= w_head_ent[1:0];
                r_upd_taken <= bus.res_taken;
                if (!(&r_stat_br)) r_stat_br <= r_stat_br + CNT_W'(1);
                if (w_mis && !(&r_stat_mis)) r_stat_mis <= r_stat_mis + CNT_W'(1);
            end
        end
    end

    assign bus.pred_ready    = ~w_full;
    assign bus.res_ready     = ~w_empty;
    assign bus.update_valid  = r_upd_valid;
    assign bus.update_pc     = r_upd_pc;
    assign bus.update_taken  = r_upd_taken;
    assign bus.update_pred   = r_upd_pred;
    assign bus.mispredict    = r_mispredict;
    assign bus.occupancy     = r_count;
    assign bus.stat_branches = r_stat_br;
    assign bus.stat_mispred  = r_stat_mis;
endmodule

// File: tb/tb_tage_branch_queue.sv
// Directed bench for tage_branch_queue: a reference FIFO model feeds an update
// scoreboard that is drained and compared every cycle.
module tb_tage_branch_queue;
    localparam int DEPTH = 8;
    localparam int PC_W  = 32;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        logic [31:0] pc;
        logic [1:0]  pred;
        logic        taken;
    } upd_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    tage_branch_queue_if #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W)) bus ();

    tage_branch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int          vectors    = 0;
    int          miscompares = 0;
    upd_t        sb[$];
    logic [33:0] mf[$];
    int          m_br = 0;
    int          m_mis = 0;
    logic [31:0] l_pc = '0;
    logic [1:0]  l_pred = '0;
    logic        l_taken = 1'b0;
    bit          exp_upd;

    logic [31:0] tr_raw [10] = '{32'h40100000, 32'h44100000, 32'h00200000, 32'h08200000,
                                 32'h40100000, 32'hA0341200, 32'h10FF0000, 32'h44100000,
                                 32'h0C200000, 32'hFCFFFF7F};
    logic [7:0]  tr_tk  [10] = '{8'h01, 8'h00, 8'h01, 8'h01, 8'h00,
                                 8'h01, 8'h00, 8'h00, 8'h01, 8'h01};

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        bus.pred_valid = 1'b0;
        bus.pred_pc    = '0;
        bus.pred_ctr   = '0;
        bus.res_valid  = 1'b0;
        bus.res_taken  = 1'b0;
        bus.flush      = 1'b0;
    endtask

    // Model effects of the inputs present now, advance one clock, then compare.
    task automatic tick();
        upd_t        u;
        logic [33:0] e;
        bit          pu;
        exp_upd = 1'b0;
        if (rst && !bus.flush) begin
            pu = bus.pred_valid && (mf.size() < DEPTH);
            if (bus.res_valid && mf.size() > 0) begin
                e       = mf.pop_front();
                u.pc    = e[33:2];
                u.pred  = e[1:0];
                u.taken = bus.res_taken;
                sb.push_back(u);
                exp_upd = 1'b1;
            end
            if (pu) mf.push_back({bus.pred_pc, bus.pred_ctr});
        end else if (rst) begin
            mf.delete();
        end
        @(posedge clk);
        #1;
        check("update_valid", 64'(bus.update_valid), 64'(exp_upd));
        if (exp_upd && sb.size() > 0) begin
            u       = sb.pop_front();
            l_pc    = u.pc;
            l_pred  = u.pred;
            l_taken = u.taken;
            if (m_br < CNT_MAX) m_br++;
            if (u.pred[1] != u.taken && m_mis < CNT_MAX) m_mis++;
        end
        check("update_pc",     64'(bus.update_pc),     64'(l_pc));
        check("update_pred",   64'(bus.update_pred),   64'(l_pred));
        check("update_taken",  64'(bus.update_taken),  64'(l_taken));
        check("mispredict",    64'(bus.mispredict),    64'(exp_upd && (l_pred[1] != l_taken)));
        check("occupancy",     64'(bus.occupancy),     64'(mf.size()));
        check("pred_ready",    64'(bus.pred_ready),    64'(mf.size() < DEPTH));
        check("res_ready",     64'(bus.res_ready),     64'(mf.size() > 0));
        check("stat_branches", 64'(bus.stat_branches), 64'(m_br));
        check("stat_mispred",  64'(bus.stat_mispred),  64'(m_mis));
        set_idle();
    endtask

    task automatic drive(input logic pv, input logic [31:0] pc, input logic [1:0] ctr,
                         input logic rv, input logic rt, input logic fl);
        bus.pred_valid = pv;
        bus.pred_pc    = pc;
        bus.pred_ctr   = ctr;
        bus.res_valid  = rv;
        bus.res_taken  = rt;
        bus.flush      = fl;
        tick();
    endtask

    initial begin
        set_idle();
        #1;
        check("rst occupancy", 64'(bus.occupancy), 64'd0);
        check("rst update_valid", 64'(bus.update_valid), 64'd0);
        check("rst update_pc", 64'(bus.update_pc), 64'd0);
        check("rst stat_branches", 64'(bus.stat_branches), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Single branch: strongly-taken prediction resolved not-taken.
        drive(1, 32'h0000_1040, 2'b11, 0, 0, 0);
        drive(0, 32'h0, 2'b00, 1, 0, 0);
        check("single update_pc", 64'(bus.update_pc), 64'h1040);
        check("single mispredict", 64'(bus.mispredict), 64'd1);
        check("single stat_mispred", 64'(bus.stat_mispred), 64'd1);
        drive(0, 32'h0, 2'b00, 0, 0, 0);

        // Fill to full, drop a ninth push and a push during a full-queue pop.
        for (int i = 0; i < DEPTH; i++) drive(1, 32'h100 + 32'(4 * i), 2'(i), 0, 0, 0);
        check("full pred_ready", 64'(bus.pred_ready), 64'd0);
        drive(1, 32'h120, 2'b10, 0, 0, 0);
        drive(1, 32'h124, 2'b10, 1, 1, 0);
        check("full first pop", 64'(bus.update_pc), 64'h100);
        for (int i = 1; i < DEPTH; i++) drive(0, 32'h0, 2'b00, 1, 1'(i), 0);
        check("fill last pop", 64'(bus.update_pc), 64'h11C);
        drive(0, 32'h0, 2'b00, 0, 0, 0);

        // Simultaneous push and pop at occupancy 4.
        for (int i = 0; i < 4; i++) drive(1, 32'h200 + 32'(4 * i), 2'b01, 0, 0, 0);
        drive(1, 32'h210, 2'b10, 1, 1, 0);
        check("simul occupancy", 64'(bus.occupancy), 64'd4);
        check("simul oldest", 64'(bus.update_pc), 64'h200);
        for (int i = 0; i < 4; i++) drive(0, 32'h0, 2'b00, 1, 0, 0);
        drive(0, 32'h0, 2'b00, 0, 0, 0);

        // Resolution with nothing queued is ignored.
        drive(0, 32'h0, 2'b00, 1, 1, 0);
        drive(0, 32'h0, 2'b00, 0, 0, 0);

        // Flush overrides a same-cycle push and pop.
        for (int i = 0; i < 5; i++) drive(1, 32'h300 + 32'(4 * i), 2'b11, 0, 0, 0);
        drive(1, 32'h400, 2'b11, 1, 0, 1);
        check("flush occupancy", 64'(bus.occupancy), 64'd0);
        check("flush no pulse", 64'(bus.update_valid), 64'd0);

        // Asynchronous reset with three entries queued, checked before any clock edge.
        for (int i = 0; i < 3; i++) drive(1, 32'h500 + 32'(4 * i), 2'b10, 0, 0, 0);
        drive(0, 32'h0, 2'b00, 1, 1, 0);
        #2;
        rst = 1'b0;
        #1;
        mf.delete();
        sb.delete();
        m_br = 0; m_mis = 0; l_pc = '0; l_pred = '0; l_taken = 1'b0;
        check("async occupancy", 64'(bus.occupancy), 64'd0);
        check("async update_valid", 64'(bus.update_valid), 64'd0);
        check("async stat_branches", 64'(bus.stat_branches), 64'd0);
        check("async stat_mispred", 64'(bus.stat_mispred), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Trace replay: byte-swapped PCs, taken byte, pushes overlapped with pops.
        for (int i = 0; i < 10; i++) begin
            drive(1, bswap(tr_raw[i]), 2'(i + 1), (i > 0), (i > 0) && (tr_tk[(i > 0) ? i - 1 : 0] != 8'h00), 0);
            if (i > 0) check("trace pc", 64'(bus.update_pc), 64'(bswap(tr_raw[i - 1])));
        end
        drive(0, 32'h0, 2'b00, 1, tr_tk[9] != 8'h00, 0);
        check("trace pc", 64'(bus.update_pc), 64'(bswap(tr_raw[9])));
        check("trace stat_branches", 64'(bus.stat_branches), 64'd10);

        // Drive the narrow stat counters past all-ones.
        for (int i = 0; i < 8; i++) begin
            drive(1, 32'h600 + 32'(4 * i), 2'b11, 0, 0, 0);
            drive(0, 32'h0, 2'b00, 1, 0, 0);
        end
        drive(0, 32'h0, 2'b00, 0, 0, 0);
        check("sat stat_branches", 64'(bus.stat_branches), 64'(CNT_MAX));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
